l2_cache_control: RTL



---
 rtl/l2_ctrl_pkg.sv | 25 ++
 rtl/l2_cache_control_if.sv | 55 +++++
 rtl/l2_perf_counter.sv | 51 +++++
 rtl/l2_cache_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/l2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : l2_ctrl_pkg
//  Purpose   : Shared types and constants for the 2-way L2 cache controller.
//  Revision  : 1.0  initial release
// ============================================================================
package l2_ctrl_pkg;

  localparam int NUM_WAYS  = 2;
  localparam int CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FILL      = 2'd3
  } l2_state_t;

  // One-hot per-way strobe for a 1-bit way index.
  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cache_control_if.sv
`default_nettype none
// ============================================================================
//  Interface : l2_cache_control_if
//  Purpose   : Upstream/downstream handshakes, array feedback and array
//              control strobes of the L2 cache controller.
//              master = surrounding cache datapath / memories,
//              slave  = the controller.
//  Revision  : 1.0  initial release
// ============================================================================
interface l2_cache_control_if;
  import l2_ctrl_pkg::*;

  // Upstream request/response
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_resp;
  // Physical memory handshake
  logic                 pmem_read;
  logic                 pmem_write;
  logic                 pmem_resp;
  // Array feedback
  logic [NUM_WAYS-1:0]  hit;
  logic [NUM_WAYS-1:0]  dirty;
  logic                 lru;
  // Array control
  logic                 array_read;
  logic [NUM_WAYS-1:0]  tag_load;
  logic [NUM_WAYS-1:0]  valid_load;
  logic [NUM_WAYS-1:0]  dirty_load;
  logic [NUM_WAYS-1:0]  data_load;
  logic                 dirty_in;
  logic                 lru_load;
  logic                 lru_in;
  logic                 data_in_sel;
  logic                 pmem_addr_sel;
  // Performance counters
  logic [CNT_WIDTH-1:0] hit_count;
  logic [CNT_WIDTH-1:0] miss_count;

  modport master (
    output mem_read, mem_write, pmem_resp, hit, dirty, lru,
    input  mem_resp, pmem_read, pmem_write, array_read, tag_load, valid_load,
           dirty_load, data_load, dirty_in, lru_load, lru_in, data_in_sel,
           pmem_addr_sel, hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit, dirty, lru,
    output mem_resp, pmem_read, pmem_write, array_read, tag_load, valid_load,
           dirty_load, data_load, dirty_in, lru_load, lru_in, data_in_sel,
           pmem_addr_sel, hit_count, miss_count
  );

endinterface
`default_nettype wire

// File: rtl/l2_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module    : l2_perf_counter
//  Purpose   : Saturating event counter with clear and preload inputs.
//              Clear has priority over load, load over increment.
//  Revision  : 1.0  initial release
// ============================================================================
module l2_perf_counter
  import l2_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + C_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`default_nettype none
// ============================================================================
//  Module    : l2_cache_control
//  Purpose   : Sequencing FSM for the 2-way set-associative L2 cache.
//              Drives array strobes and datapath muxes, the upstream
//              request/response handshake, the pmem writeback/fill
//              handshake, and saturating hit/miss counters.
//  Revision  : 1.0  initial release
// ============================================================================
module l2_cache_control
  import l2_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  l2_cache_control_if.slave  cache_if
);

  l2_state_t state_q, state_d;
  logic      victim_q, victim_d;   // way chosen for eviction on a miss
  logic      refill_q, refill_d;   // set while the post-fill COMPARE runs

  logic req_w;
  logic hit_any_w;
  logic hit_way_w;
  logic write_w;

  logic                o_mem_resp;
  logic                o_pmem_read;
  logic                o_pmem_write;
  logic                o_array_read;
  logic [NUM_WAYS-1:0] o_tag_load;
  logic [NUM_WAYS-1:0] o_valid_load;
  logic [NUM_WAYS-1:0] o_dirty_load;
  logic [NUM_WAYS-1:0] o_data_load;
  logic                o_dirty_in;
  logic                o_lru_load;
  logic                o_lru_in;
  logic                o_data_in_sel;
  logic                o_pmem_addr_sel;

  logic hit_inc_w;
  logic miss_inc_w;

  assign req_w     = cache_if.mem_read | cache_if.mem_write;
  assign hit_any_w = |cache_if.hit;
  // Way 0 wins if both ways ever report a hit.
  assign hit_way_w = ~cache_if.hit[0];
  // Read and write together is handled as a write.
  assign write_w   = cache_if.mem_write;

  // Next-state logic: state, victim latch and refill flag.
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    refill_d = refill_q;
    case (state_q)
      ST_IDLE: begin
        refill_d = 1'b0;
        if (req_w) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit_any_w) begin
          state_d = ST_IDLE;
        end else begin
          victim_d = cache_if.lru;
          state_d  = cache_if.dirty[cache_if.lru] ? ST_WRITEBACK : ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        if (cache_if.pmem_resp) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (cache_if.pmem_resp) begin
          state_d  = ST_COMPARE;
          refill_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: array strobes, mux selects and handshakes per state.
  always_comb begin
    o_mem_resp      = 1'b0;
    o_pmem_read     = 1'b0;
    o_pmem_write    = 1'b0;
    o_array_read    = 1'b0;
    o_tag_load      = '0;
    o_valid_load    = '0;
    o_dirty_load    = '0;
    o_data_load     = '0;
    o_dirty_in      = 1'b0;
    o_lru_load      = 1'b0;
    o_lru_in        = 1'b0;
    o_data_in_sel   = 1'b0;
    o_pmem_addr_sel = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_array_read = req_w;
      end
      ST_COMPARE: begin
        if (hit_any_w) begin
          o_mem_resp = 1'b1;
          o_lru_load = 1'b1;
          o_lru_in   = ~hit_way_w;
          if (write_w) begin
            o_data_load  = way_onehot(hit_way_w);
            o_dirty_load = way_onehot(hit_way_w);
            o_dirty_in   = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        o_pmem_write    = 1'b1;
        o_pmem_addr_sel = 1'b1;
        if (cache_if.pmem_resp) begin
          o_dirty_load = way_onehot(victim_q);
        end
      end
      ST_FILL: begin
        o_pmem_read = 1'b1;
        if (cache_if.pmem_resp) begin
          o_data_load   = way_onehot(victim_q);
          o_tag_load    = way_onehot(victim_q);
          o_valid_load  = way_onehot(victim_q);
          o_dirty_load  = way_onehot(victim_q);
          o_data_in_sel = 1'b1;
          // Re-read so the same-index write-forward presents the new line.
          o_array_read  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
    end
  end

  // The post-fill COMPARE is not a new access; only the first COMPARE counts.
  assign hit_inc_w  = (state_q == ST_COMPARE) &  hit_any_w & ~refill_q;
  assign miss_inc_w = (state_q == ST_COMPARE) & ~hit_any_w & ~refill_q;

  l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (hit_inc_w),
    .clr_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .count_o    (cache_if.hit_count)
  );

  l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (miss_inc_w),
    .clr_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .count_o    (cache_if.miss_count)
  );

  assign cache_if.mem_resp      = o_mem_resp;
  assign cache_if.pmem_read     = o_pmem_read;
  assign cache_if.pmem_write    = o_pmem_write;
  assign cache_if.array_read    = o_array_read;
  assign cache_if.tag_load      = o_tag_load;
  assign cache_if.valid_load    = o_valid_load;
  assign cache_if.dirty_load    = o_dirty_load;
  assign cache_if.data_load     = o_data_load;
  assign cache_if.dirty_in      = o_dirty_in;
  assign cache_if.lru_load      = o_lru_load;
  assign cache_if.lru_in        = o_lru_in;
  assign cache_if.data_in_sel   = o_data_in_sel;
  assign cache_if.pmem_addr_sel = o_pmem_addr_sel;

endmodule
`default_nettype wire
